// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared FSM states, mode encodings and clog2 helper for the pooling engine
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    EMIT
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/pool_reduce.sv
// rtl/pool_reduce.sv - four-sample accumulator producing the max or truncated average of a window
module pool_reduce
  import pool_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          sample_valid,
  input  logic          mode,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] result,
  output logic [2:0]    count
);

  logic [DW+1:0] acc;
  logic [DW+1:0] sample_ext;

  assign sample_ext = {2'b00, sample};

  // acc starts at zero, so the first max comparison always takes the sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (sample_valid) begin
      count <= count + 3'd1;
      if (mode == MODE_AVG) begin
        acc <= acc + sample_ext;
      end else if (sample_ext > acc) begin
        acc <= sample_ext;
      end
    end
  end

  assign result = (mode == MODE_AVG) ? acc[DW+1:2] : acc[DW-1:0];

endmodule

// File: rtl/pool2x2_engine.sv
// rtl/pool2x2_engine.sv - walks a CH x MAP_H x MAP_W buffer and streams one 2x2 pooled value per window
module pool2x2_engine
  import pool_pkg::*;
#(
  parameter  int DW     = 8,
  parameter  int MAP_W  = 8,
  parameter  int MAP_H  = 8,
  parameter  int CH     = 32,
  parameter  int RD_LAT = 2,
  localparam int AW     = clog2(CH * MAP_W * MAP_H),
  localparam int NW     = CH * (MAP_W / 2) * (MAP_H / 2),
  localparam int CW     = clog2(NW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_idx,
  output logic          out_last
);

  localparam int CXW = clog2(MAP_W);
  localparam logic [CXW-1:0] C_LAST = CXW'(MAP_W - 2);

  state_t              state;
  state_t              state_nx;
  logic [1:0]          fetch_cnt;
  logic [AW-1:0]       base;
  logic [CXW-1:0]      col;
  logic [CW-1:0]       idx;
  logic                mode_q;
  logic                done_q;
  logic [RD_LAT-1:0]   rd_pipe;
  logic                smp_valid;
  logic                red_clear;
  logic [2:0]          red_count;
  logic [DW-1:0]       red_result;
  logic                last_win;

  assign last_win  = (idx == CW'(NW - 1));
  assign smp_valid = rd_pipe[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    red_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = FETCH;
          red_clear = 1'b1;
        end
      end
      FETCH: begin
        if (fetch_cnt == 2'd3) state_nx = DRAIN;
      end
      DRAIN: begin
        // leave on the cycle the fourth sample is presented so out_valid rises with its capture
        if (smp_valid && red_count == 3'd3) state_nx = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (last_win) begin
            state_nx = IDLE;
          end else begin
            state_nx  = FETCH;
            red_clear = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      base      <= '0;
      col       <= '0;
      idx       <= '0;
      mode_q    <= MODE_MAX;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == EMIT) && out_ready && last_win;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            fetch_cnt <= '0;
            base      <= '0;
            col       <= '0;
            idx       <= '0;
          end
        end
        FETCH: fetch_cnt <= fetch_cnt + 2'd1;
        EMIT: begin
          if (out_ready) begin
            fetch_cnt <= '0;
            if (last_win) begin
              base <= '0;
              col  <= '0;
              idx  <= '0;
            end else begin
              idx <= idx + CW'(1);
              // a row wrap and a channel wrap both move the top-left corner by MAP_W+2
              if (col == C_LAST) begin
                col  <= '0;
                base <= base + AW'(MAP_W + 2);
              end else begin
                col  <= col + CXW'(2);
                base <= base + AW'(2);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // tracks which cycles carry returning read data; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  pool_reduce #(
    .DW(DW)
  ) u_reduce (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (red_clear),
    .sample_valid(smp_valid),
    .mode        (mode_q),
    .sample      (rd_data),
    .result      (red_result),
    .count       (red_count)
  );

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign rd_en     = (state == FETCH);
  assign rd_addr   = base + (fetch_cnt[1] ? AW'(MAP_W) : AW'(0)) + AW'(fetch_cnt[0]);
  assign out_valid = (state == EMIT);
  assign out_data  = red_result;
  assign out_idx   = idx;
  assign out_last  = (state == EMIT) && last_win;

endmodule
